hilo_muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.

---
 rtl/hilo_muldiv_unit.sv | 136 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit with HI/LO result registers. Executes
//   MULT, MULTU, DIV and DIVU at one bit per cycle; signed operations run on
//   magnitudes and the result is sign-corrected when it is written to HI/LO.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start, op     request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), sampled in IDLE
//   a, b          multiplicand/dividend, multiplier/divisor, sampled with start
//   cancel        abort the operation in flight (pipeline flush)
//   busy          operation in flight (pipeline stall)
//   done          one-cycle pulse when hi/lo take a new result
//   hi, lo        product halves, or remainder / quotient
//   div_by_zero   set with done for a divide by zero, held until the next done
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0] m, p_hi, p_lo, a_raw;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, res_hi, res_lo;
  logic [WIDTH:0]   madd, trial, diff;
  logic signed [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  assign busy = (state != IDLE);

  // One iteration: p_hi is the running product-high / partial remainder,
  // p_lo holds the multiplier being consumed or the dividend shifting out
  // while quotient bits shift in.
  always_comb begin
    madd  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
    trial = {p_hi, p_lo[WIDTH-1]};
    diff  = trial - {1'b0, m};
    if (is_div) begin
      // Partial remainder is below the divisor, so a clear top bit of diff
      // means the trial subtraction succeeded.
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {p_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {nxt_hi, nxt_lo} = {madd, p_lo[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step's outcome
  always_comb begin
    prod   = {nxt_hi, nxt_lo};
    res_hi = nxt_hi;
    res_lo = nxt_lo;
    if (!is_div) begin
      if (neg_q) prod = -prod;
      {res_hi, res_lo} = prod;
    end else if (dz) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_lo = neg_if(nxt_lo, neg_q);
      res_hi = neg_if(nxt_hi, neg_r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            is_div <= op[1];
            neg_q  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= !op[0] && a[WIDTH-1];
            dz     <= op[1] && (b == '0);
            a_raw  <= a;
            p_hi   <= '0;
            m      <= op[1] ? mag(b, !op[0]) : mag(a, !op[0]);
            p_lo   <= op[1] ? mag(a, !op[0]) : mag(b, !op[0]);
            cnt    <= CNT_W'(WIDTH);
            state  <= CALC;
          end
        end
        CALC: begin
          p_hi <= nxt_hi;
          p_lo <= nxt_lo;
          cnt  <= cnt - 1'b1;
          if (cancel) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            done        <= 1'b1;
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= dz;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        cancel = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  hilo_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference result {dz, hi, lo} from plain arithmetic
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    logic [31:0] uq, ur;
    case (o)
      2'b00: begin sp = longint'($signed(x)) * longint'($signed(y)); return {1'b0, sp[63:0]}; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; return {1'b0, up}; end
      2'b10: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {1'b0, r, q};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        uq = x / y;
        ur = x % y;
        return {1'b0, ur, uq};
      end
    endcase
  endfunction

  // Transaction-level model: cycles of busy remaining, pending result
  int          rem = 0;
  logic        m_done = 0, m_dz = 0, started = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [64:0] pend;

  always @(posedge clk) begin
    if (rst) begin
      rem = 0; m_done = 0; m_hi = 0; m_lo = 0; m_dz = 0; started = 1;
    end else begin
      m_done = 0;
      if (rem == 0) begin
        if (start && !cancel) begin
          rem  = WIDTH + 1;
          pend = ref_op(op, a, b);
        end
      end else if (cancel && rem > 1) begin
        rem = 0;
      end else begin
        rem--;
        if (rem == 1) begin
          m_done = 1;
          {m_dz, m_hi, m_lo} = pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      tests++;
      if (busy !== (rem != 0) || done !== m_done || hi !== m_hi || lo !== m_lo || div_by_zero !== m_dz) begin
        fails++;
        $display("FAIL cycle_check t=%0t got busy=%0d done=%0d hi=%h lo=%h dz=%0d want busy=%0d done=%0d hi=%h lo=%h dz=%0d",
                 $time, busy, done, hi, lo, div_by_zero, (rem != 0), m_done, m_hi, m_lo, m_dz);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int k;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk({name, " busy_first"}, busy, 1);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, k, 33);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    chk({name, " dz"}, div_by_zero, ed);
    @(negedge clk);
    chk({name, " idle_after"}, busy, 0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 20);
      5: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset hilo", {hi, lo}, 64'h0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", 2'b00, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_neg", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);

    // reset in the middle of a MULT
    op = 2'b00; a = 32'd1234; b = 32'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid hilo", {hi, lo}, 64'h0);
    chk("rst_mid dz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // cancel: load (1,2), abort a DIVU, ignored start while busy
    run_op("load_12", 2'b11, 32'd5, 32'd2, 32'd1, 32'd2, 1'b0);
    op = 2'b11; a = 32'd50; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      start = (k == 4);
      @(negedge clk);
      chk("cancel no_done", done, 0);
    end
    start = 1'b0;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy_low", busy, 0);
    chk("cancel hilo_kept", {hi, lo}, {32'd1, 32'd2});
    repeat (3) @(negedge clk);
    chk("cancel stays_idle", busy, 0);

    // randomized phase, checked every cycle by the model compare
    for (int c = 0; c < 4000; c++) begin
      start  = ($urandom_range(0, 2) == 0);
      op     = 2'($urandom_range(0, 3));
      a      = rnd_val();
      b      = rnd_val();
      cancel = ($urandom_range(0, 59) == 0);
      rst    = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    start = 1'b0; cancel = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
